nr_recip_ctrl: RTL

NR_RECIP_CTRL -- requirements
Module: nr_recip_ctrl

---
 rtl/nr_recip_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/nr_recip_ctrl.sv
// Newton-Raphson reciprocal sequencer: x <- x * (2 - d*x), ITER times.
// All FP math runs in an external combinational multiplier and adder.
module nr_recip_ctrl #(
  parameter int ITER = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] d_in,
  input  logic [31:0] x0_in,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_out,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_out,
  output logic [31:0] result,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [2:0]  CNT_LAST = 3'(ITER - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL1 = 3'd1,
    SUB  = 3'd2,
    MUL2 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [31:0] d_reg, x_reg, t_reg, u_reg, result_r;
  logic        d_zero, last_iter, accept;

  assign d_zero    = (d_in[30:0] == 31'h0);
  assign last_iter = (cnt == CNT_LAST);
  assign accept    = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and operand steering; unused operand ports stay at zero.
  always_comb begin
    state_nxt = state;
    mul_a     = 32'h0;
    mul_b     = 32'h0;
    add_a     = 32'h0;
    add_b     = 32'h0;
    case (state)
      IDLE: if (start) state_nxt = d_zero ? DONE : MUL1;
      MUL1: begin
        mul_a     = d_reg;
        mul_b     = x_reg;
        state_nxt = SUB;
      end
      SUB: begin
        add_a     = FP_TWO;
        add_b     = {~t_reg[31], t_reg[30:0]};
        state_nxt = MUL2;
      end
      MUL2: begin
        mul_a     = x_reg;
        mul_b     = u_reg;
        state_nxt = last_iter ? DONE : MUL1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 3'd0;
      d_reg    <= 32'h0;
      x_reg    <= 32'h0;
      t_reg    <= 32'h0;
      u_reg    <= 32'h0;
      result_r <= 32'h0;
    end else begin
      if (accept) begin
        d_reg <= d_in;
        x_reg <= x0_in;
        cnt   <= 3'd0;
        // zero divisor skips the iterations and returns signed infinity
        if (d_zero) result_r <= {d_in[31], 8'hFF, 23'h0};
      end
      if (state == MUL1) t_reg <= mul_out;
      if (state == SUB)  u_reg <= add_out;
      if (state == MUL2) begin
        x_reg <= mul_out;
        if (last_iter) result_r <= mul_out;
        else           cnt      <= cnt + 3'd1;
      end
    end
  end

  assign result = result_r;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule
